// File: rtl/fir_pkg.sv
// Shared constants, FSM state type and the 32-tap coefficient set for the FIR MAC engine.
package fir_pkg;

    localparam int unsigned TAPS = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 16;
    localparam int unsigned CW   = 20;
    localparam int unsigned ACCW = 40;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StOut
    } state_e;

    // Symmetric low-pass set, Q16 scale; sums to 65534.
    localparam int COEF_TABLE [TAPS] = '{
        -98, -122, -89, 59, 331, 586, 546, -28,
        -1083, -2102, -2226, -652, 2842, 7596, 12190, 15017,
        15017, 12190, 7596, 2842, -652, -2226, -2102, -1083,
        -28, 546, 586, 331, 59, -89, -122, -98
    };

    function automatic logic signed [CW-1:0] coef_at(input logic [AW-1:0] idx);
        return CW'(COEF_TABLE[idx]);
    endfunction

endpackage

// File: rtl/fir_sample_ring.sv
// Circular sample history: one synchronous write port, one combinational read port.
module fir_sample_ring
    import fir_pkg::*;
#(
    parameter int unsigned Depth = TAPS,
    parameter int unsigned Width = DW,
    parameter int unsigned IdxW  = AW
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_en_i,
    input  logic [IdxW-1:0]         wr_ptr_i,
    input  logic signed [Width-1:0] wr_data_i,
    input  logic [IdxW-1:0]         rd_idx_i,
    output logic signed [Width-1:0] rd_data_o
);

    logic signed [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_ptr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared MAC walks all taps per accepted sample, then rounds and clamps.
module fir_mac_sequencer
    import fir_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] data_in,
    output logic [AW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic signed [DW-1:0] Y,
    output logic                 valid_out,
    output logic                 busy
);

    localparam int unsigned PW = DW + CW;

    state_e                 state_q;
    logic [AW-1:0]          k_q;
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          newest_q;
    logic signed [ACCW-1:0] acc_q;
    logic signed [ACCW-1:0] acc_d;
    logic signed [DW-1:0]   y_q;
    logic signed [DW-1:0]   y_d;
    logic                   valid_q;

    logic                   accept;
    logic signed [DW-1:0]   hist_rd;
    logic signed [PW-1:0]   prod;
    logic [DW:0]            rnd;
    logic                   acc_fits;

    assign in_ready  = rst && (state_q == StIdle);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != StIdle);
    assign coef_addr = (state_q == StMac) ? k_q : '0;
    assign Y         = y_q;
    assign valid_out = valid_q;

    fir_sample_ring #(
        .Depth (TAPS),
        .Width (DW),
        .IdxW  (AW)
    ) u_ring (
        .clk_i     (clk),
        .rst_ni    (rst),
        .wr_en_i   (accept),
        .wr_ptr_i  (wr_ptr_q),
        .wr_data_i (data_in),
        .rd_idx_i  (newest_q - k_q),
        .rd_data_o (hist_rd)
    );

    assign prod  = hist_rd * coef_data;
    assign acc_d = acc_q + {{(ACCW - PW){prod[PW-1]}}, prod};

    // Truncate to Q16, nudge negatives up by one LSB, clamp on 32-bit or 16-bit overflow.
    always_comb begin
        rnd      = {acc_q[31], acc_q[31:16]} + {{DW{1'b0}}, acc_q[ACCW-1]};
        acc_fits = (acc_q[ACCW-1:31] == '0) || (acc_q[ACCW-1:31] == '1);
        y_d      = rnd[DW-1:0];
        if (!acc_fits || (rnd[DW] != rnd[DW-1])) begin
            y_d = acc_q[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            k_q      <= '0;
            wr_ptr_q <= '0;
            newest_q <= '0;
            y_q      <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        newest_q <= wr_ptr_q;
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        k_q      <= '0;
                        acc_q    <= '0;
                        state_q  <= StMac;
                    end
                end
                StMac: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + 1'b1;
                    if (k_q == AW'(TAPS - 1)) begin
                        state_q <= StOut;
                    end
                end
                StOut: begin
                    y_q     <= y_d;
                    valid_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
